muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer beside the EX-stage ALU; owns the HI/LO registers.
//  Accepts mult/div/mthi/mtlo from EX, holds a busy window of fixed latency and commits HI/LO.
//  Raises a stall request while a later md instruction or mfhi/mflo reaches EX during busy.
// PARAMETERS
//  MULT_CYCLES  5   cycles from accepted MULT/MULTU to HI/LO commit (>=1)
//  DIV_CYCLES   10  cycles from accepted DIV/DIVU to HI/LO commit (>=1)
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-low; clears all state
//  start     in   1   md instruction valid in EX this cycle
//  op        in   3   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO; 6-7 reserved = no-op
//  a         in   32  forwarded rs operand (post-forward-mux value)
//  b         in   32  forwarded rt operand
//  md_read   in   1   mfhi/mflo in EX this cycle
//  busy      out  1   operation in flight (registered)
//  done      out  1   one-cycle pulse on the HI/LO commit edge (registered)
//  stall     out  1   combinational: busy & (start | md_read)
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  Reset: busy=0, done=0, hi=0, lo=0, state IDLE, counter=0; takes effect immediately, aborts in-flight op.
//  States IDLE, BUSY.
//  IDLE & start & op in 0..3: latch a, b, op; counter <= (MULT?MULT_CYCLES:DIV_CYCLES)-1;
//   -> BUSY; busy=1 from next cycle.
//  IDLE & start & op 4/5: hi<=a / lo<=a at next edge; no busy, no done; stays IDLE.
//  BUSY: counter decrements each cycle. At counter==0: hi/lo commit, done=1 for one cycle,
//   busy=0 on that same edge, -> IDLE.
//  Latency: start at edge N accepted; hi/lo valid after edge N+LAT; mfhi at N+LAT does not stall.
//  start or md_read during BUSY: not accepted; stall=1 so the pipeline holds EX; request re-sampled
//   every cycle; accepted on the first IDLE cycle.
//  start in IDLE on the same edge busy clears (done cycle): accepted normally, back-to-back allowed.
//  Result widths: MULT signed 32x32->64, MULTU unsigned; {hi,lo} = product.
//  DIV signed: lo=quotient truncated toward zero, hi=remainder with sign of dividend; DIVU unsigned.
//  Divide by zero: full DIV_CYCLES busy window, done pulses, hi/lo left unchanged.
//  DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  Operands sampled only at acceptance; a/b changes during BUSY are ignored.
//  Reserved op with start: ignored entirely (no state change, no stall in IDLE).
// CONFIGURATION
//  MD_FLUSH_EN defined: adds input port flush (1 bit). flush=1 in BUSY -> IDLE at next edge,
//   busy=0, no commit, no done; flush=1 with start in IDLE -> start ignored. flush dominates start.
//  MD_FLUSH_EN undefined: no flush port; an accepted op always commits.
// STRUCTURE
//  Shared header md_defines.vh: op encodings MD_MULT..MD_MTLO, state encodings MD_IDLE/MD_BUSY.
//  Header also included by the decode controller.
//  One sub-module md_compute: combinational 64-bit result from latched op/a/b (mult, div, signedness,
//   div-by-zero flag). muldiv_ctrl keeps FSM, counter, HI/LO and stall logic.
// TESTING
//  MULT a=0xFFFFFFFE(-2) b=3 -> busy 5 cycles, done pulse, hi=0xFFFFFFFF lo=0xFFFFFFFA.
//  DIVU a=100 b=7, then md_read during busy -> stall=1 all 10 cycles.
//   Then lo=14, hi=2; stall=0 on the done cycle.
//  DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV by 0 -> done pulses, hi/lo unchanged.
//  MTHI a=0x1234 in IDLE -> hi=0x1234 next edge, busy stays 0.
//   Back-to-back MULTU issued on a done cycle -> accepted.
//  reset low for one cycle at DIV cycle 4 -> busy=0, hi=lo=0 immediately; no done pulse.
//  MD_FLUSH_EN: flush at MULT cycle 2 -> busy=0 next edge, hi/lo keep prior values, no done.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: md op codes and FSM states.
// Imported by the sequencer and by the decode controller.
package muldiv_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Ops 0..3 run through the multi-cycle busy window.
    function automatic logic is_md_arith(input logic [2:0] op);
        return op <= MD_DIVU;
    endfunction

    function automatic logic is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_move(input logic [2:0] op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_md_compute.sv
// Combinational HI/LO result for the latched md operation: 64-bit product or
// {remainder, quotient}, plus a divide-by-zero flag so the caller can skip the commit.
module muldiv_ctrl_md_compute
    import muldiv_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic               is_signed;
    logic [63:0]        ext_a;
    logic [63:0]        ext_b;
    logic [63:0]        product;
    logic [31:0]        div_b_safe;
    logic signed [32:0] div_a;
    logic signed [32:0] div_b;
    logic [31:0]        quot;
    logic [31:0]        rem;

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign ext_a   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    assign ext_b   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    assign product = ext_a * ext_b;

    // 33-bit signed divide covers DIVU and makes 0x80000000 / -1 wrap to 0x80000000.
    assign div_by_zero = (b == 32'd0);
    assign div_b_safe  = div_by_zero ? 32'd1 : b;
    assign div_a       = $signed({is_signed & a[31], a});
    assign div_b       = $signed({is_signed & div_b_safe[31], div_b_safe});
    assign quot        = 32'(div_a / div_b);
    assign rem         = 32'(div_a % div_b);

    assign result = is_mult(op) ? product : {rem, quot};

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; fixed-latency busy window and EX stall.
// Build option MD_FLUSH_EN adds a flush input that cancels an in-flight operation.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_read,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output md_state_e   state_dbg
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state;
    md_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [63:0]      result;
    logic             div_by_zero;
    logic             flush_w;
    logic             accept_md;
    logic             accept_mt;
    logic             commit;
    logic             abort;

`ifdef MD_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    muldiv_ctrl_md_compute u_compute (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (accept_md)              state_nxt = MD_BUSY;
            MD_BUSY: if (abort || commit)        state_nxt = MD_IDLE;
            default:                             state_nxt = MD_IDLE;
        endcase
    end

    // Handshake: a request (start or md_read) is taken only in IDLE; while busy it is
    // refused and stall holds EX so the same request is presented again next cycle.
    always_comb begin
        accept_md = (state == MD_IDLE) && start && !flush_w && is_md_arith(op);
        accept_mt = (state == MD_IDLE) && start && !flush_w && is_move(op);
        abort     = (state == MD_BUSY) && flush_w;
        commit    = (state == MD_BUSY) && !flush_w && (cnt == '0);
        busy      = (state == MD_BUSY);
        stall     = busy && (start || md_read);
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            op_q <= MD_MULT;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= commit;
            if (accept_md) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
                cnt  <= is_mult(op) ? MULT_LOAD : DIV_LOAD;
            end else if (abort) begin
                cnt <= '0;
            end else if (busy && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // A zero divisor still runs the full window but leaves HI/LO untouched.
            if (commit && !(div_by_zero && !is_mult(op_q))) begin
                hi <= result[63:32];
                lo <= result[31:0];
            end else if (accept_mt) begin
                if (op == MD_MTHI) hi <= a;
                else               lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized bench for muldiv_ctrl against an arithmetic HI/LO reference model.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_read;
`ifdef MD_FLUSH_EN
    logic        flush;
`endif
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    md_state_e   state_dbg;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] ref_hi   = '0;
    logic [31:0] ref_lo   = '0;
    logic [63:0] exp_q[$];

    muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .md_read   (md_read),
`ifdef MD_FLUSH_EN
        .flush     (flush),
`endif
        .busy      (busy),
        .done      (done),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural effect of one op on HI/LO, plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        sa = $signed(av);
        sb = $signed(bv);
        ua = av;
        ub = bv;
        case (o)
            MD_MULT:  begin p = sa * sb; ref_hi = p[63:32]; ref_lo = p[31:0]; end
            MD_MULTU: begin pu = ua * ub; ref_hi = pu[63:32]; ref_lo = pu[31:0]; end
            MD_DIV:   if (bv != 0) begin p = sa / sb; ref_lo = p[31:0]; p = sa % sb; ref_hi = p[31:0]; end
            MD_DIVU:  if (bv != 0) begin ref_lo = av / bv; ref_hi = av % bv; end
            MD_MTHI:  ref_hi = av;
            MD_MTLO:  ref_lo = av;
            default:  ;
        endcase
    endtask

    // Driver: issue an arithmetic op and follow it through its busy window.
    // pend: 0 quiet, 1 md_read held during busy, 2 an MTHI start held during busy.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input int pend);
        int          lat;
        logic [63:0] e;
        start = 1'b1; op = o; a = av; b = bv;
        model(o, av, bv);
        exp_q.push_back({ref_hi, ref_lo});
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
        lat = (o == MD_MULT || o == MD_MULTU) ? MC : DC;
        for (int i = 0; i < lat; i++) begin
            md_read = (pend == 1);
            if (pend == 2) begin start = 1'b1; op = MD_MTHI; end
            #2;
            check("busy_window", busy, 1);
            check("done_early", done, 0);
            check("stall_busy", stall, pend != 0);
            tick();
        end
        start = 1'b0;
        md_read = (pend == 1);
        #2;
        e = exp_q.pop_front();
        check("busy_clear", busy, 0);
        check("done_pulse", done, 1);
        check("stall_done", stall, 0);
        check("hi_commit", hi, e[63:32]);
        check("lo_commit", lo, e[31:0]);
        md_read = 1'b0;
    endtask

    task automatic move(input logic [2:0] o, input logic [31:0] av);
        start = 1'b1; op = o; a = av;
        model(o, av, 32'd0);
        tick();
        start = 1'b0;
        check("mt_hi", hi, ref_hi);
        check("mt_lo", lo, ref_lo);
        check("mt_busy", busy, 0);
        check("mt_done", done, 0);
    endtask

    task automatic reserved_op();
        start = 1'b1; op = 3'd6 + 3'($urandom_range(0, 1)); a = $urandom; b = $urandom;
        #1;
        check("rsv_stall", stall, 0);
        tick();
        start = 1'b0;
        check("rsv_busy", busy, 0);
        check("rsv_hi", hi, ref_hi);
        check("rsv_lo", lo, ref_lo);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] av, bv;

        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; md_read = 1'b0;
`ifdef MD_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_state", 32'(state_dbg), 32'(MD_IDLE));
        md_read = 1'b1; start = 1'b1; op = MD_MULT;
        #1;
        check("rst_stall", stall, 0);
        start = 1'b0; md_read = 1'b0;
        reset = 1'b1;
        tick();

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFFA);
        tick();
        issue(MD_DIVU, 32'd100, 32'd7, 1);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        tick();
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        issue(MD_DIV, 32'd55, 32'd0, 2);
        check("div0_lo", lo, 32'hFFFF_FFFD);
        tick();
        move(MD_MTHI, 32'h0000_1234);
        check("mthi_val", hi, 32'h0000_1234);
        move(MD_MTLO, 32'hCAFE_0001);
        issue(MD_MULT, 32'd7, 32'hFFFF_FFFF, 0);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);
        reserved_op();

        for (int n = 0; n < 24; n++) begin
            o  = 3'($urandom_range(0, 6));
            av = $urandom;
            bv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 1) bv = 32'($urandom_range(1, 17));
            if (o <= MD_DIVU)      issue(o, av, bv, int'($urandom_range(0, 2)));
            else if (o <= MD_MTLO) move(o, av);
            else                   reserved_op();
            repeat ($urandom_range(0, 2)) tick();
        end

        issue(MD_MULTU, 32'd3, 32'd5, 0);
        start = 1'b1; op = MD_DIV; a = 32'd50; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        ref_hi = '0; ref_lo = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < DC + 2; i++) begin
            tick();
            check("arst_no_done", done, 0);
        end
        check("arst_hi_kept", hi, 0);

`ifdef MD_FLUSH_EN
        issue(MD_MULTU, 32'd11, 32'd13, 0);
        start = 1'b1; op = MD_MULT; a = 32'd7; b = 32'd9;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        check("flush_hi", hi, ref_hi);
        check("flush_lo", lo, ref_lo);
        for (int i = 0; i < MC; i++) begin
            tick();
            check("flush_no_done", done, 0);
        end
        flush = 1'b1; start = 1'b1; op = MD_MTHI; a = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; start = 1'b0;
        check("flush_mt_hi", hi, ref_hi);
        check("flush_mt_busy", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
